// File: rtl/ftsd_scroll_scanner.sv
// ftsd_scroll_scanner: scrolls a song name across a 4-digit fourteen-segment display.
// Each digit gets one blank cycle and then SCAN_DIV cycles of display.
module ftsd_scroll_scanner #(
    parameter int SCAN_DIV   = 50000,
    parameter int SCROLL_DIV = 200,
    parameter int MSG_LEN    = 6,
    parameter int NUM_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  song,
    output logic [2:0]  song_sel,
    output logic [2:0]  char_idx,
    input  logic [14:0] char_pattern,
    output logic [3:0]  ftsd_ctl,
    output logic [14:0] ftsd_seg,
    output logic [2:0]  scroll_pos,
    output logic        scroll_step
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state;
    logic [1:0]    digit;
    logic [SW-1:0] scan_cnt;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    k;
    logic          in_msg;
    logic [14:0]   pattern;

    // Positions past the end of the message are shown blank whatever the encoder returns.
    assign k        = {1'b0, scroll_pos} + {2'b00, digit};
    assign in_msg   = k < 4'(MSG_LEN);
    assign char_idx = in_msg ? k[2:0] : 3'd7;
    assign pattern  = in_msg ? char_pattern : 15'h7FFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            digit       <= 2'd0;
            scan_cnt    <= '0;
            frame_cnt   <= '0;
            scroll_pos  <= 3'd0;
            scroll_step <= 1'b0;
            song_sel    <= 3'd0;
            ftsd_ctl    <= 4'hF;
            ftsd_seg    <= 15'h7FFF;
        end else begin
            song_sel    <= song;
            scroll_step <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                digit     <= 2'd0;
                scan_cnt  <= '0;
                frame_cnt <= '0;
                ftsd_ctl  <= 4'hF;
                ftsd_seg  <= 15'h7FFF;
            end else if (song != song_sel) begin
                state      <= BLANK;
                digit      <= 2'd0;
                scan_cnt   <= '0;
                frame_cnt  <= '0;
                scroll_pos <= 3'd0;
                ftsd_ctl   <= 4'hF;
                ftsd_seg   <= 15'h7FFF;
            end else begin
                case (state)
                    IDLE: state <= BLANK;
                    BLANK: begin
                        state    <= SHOW;
                        ftsd_seg <= pattern;
                        ftsd_ctl <= ~(4'b1000 >> digit);
                    end
                    SHOW: begin
                        if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                            scan_cnt <= '0;
                            digit    <= digit + 2'd1;
                            state    <= BLANK;
                            ftsd_ctl <= 4'hF;
                            ftsd_seg <= 15'h7FFF;
                            if (digit == 2'(NUM_DIGITS - 1)) begin
                                if (frame_cnt == FW'(SCROLL_DIV - 1)) begin
                                    frame_cnt   <= '0;
                                    scroll_pos  <= scroll_pos == 3'(MSG_LEN - 1) ? 3'd0 : scroll_pos + 3'd1;
                                    scroll_step <= 1'b1;
                                end else begin
                                    frame_cnt <= frame_cnt + FW'(1);
                                end
                            end
                        end else begin
                            scan_cnt <= scan_cnt + SW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
